// File: rtl/train_pkg.sv
// Shared definitions for the train sequencer and the timer selector datapath.
// Contents: timer width, default departure-warning duration, state codes and
// the state enum built on those codes.
package train_pkg;

  localparam int unsigned TIMER_W = 19;

  // Departure-warning duration in clk cycles; not runtime-configurable.
  localparam logic [TIMER_W-1:0] T_WARN_DEFAULT = 19'd4096;

  // State codes; the selector datapath decodes these directly.
  localparam logic [3:0] ST_IDLE  = 4'b0000;
  localparam logic [3:0] ST_WARN  = 4'b0010;
  localparam logic [3:0] ST_RUN   = 4'b0011;
  localparam logic [3:0] ST_BRAKE = 4'b0100;
  localparam logic [3:0] ST_DWELL = 4'b0101;
  localparam logic [3:0] ST_FAULT = 4'b1111;

  typedef enum logic [3:0] {
    StIdle  = ST_IDLE,
    StWarn  = ST_WARN,
    StRun   = ST_RUN,
    StBrake = ST_BRAKE,
    StDwell = ST_DWELL,
    StFault = ST_FAULT
  } state_e;

endpackage

// File: rtl/train_sequencer_if.sv
// Operator/sensor inputs and actuator/status outputs of the train sequencer.
// master : drives start/stop_req/station_det/obstacle and the t_* durations,
//          observes present_state, timer_val and the decoded enables.
// slave  : the sequencer side of the same bundle.
interface train_sequencer_if import train_pkg::*; ();

  logic               start;
  logic               stop_req;
  logic               station_det;
  logic               obstacle;
  logic [TIMER_W-1:0] t_run;
  logic [TIMER_W-1:0] t_brake;
  logic [TIMER_W-1:0] t_dwell;
  logic [3:0]         present_state;
  logic [TIMER_W-1:0] timer_val;
  logic               motor_en;
  logic               brake_en;
  logic               door_open;
  logic               busy;
  logic               done;

  modport master (
    output start, stop_req, station_det, obstacle, t_run, t_brake, t_dwell,
    input  present_state, timer_val, motor_en, brake_en, door_open, busy, done
  );

  modport slave (
    input  start, stop_req, station_det, obstacle, t_run, t_brake, t_dwell,
    output present_state, timer_val, motor_en, brake_en, door_open, busy, done
  );

endinterface

// File: rtl/train_timer.sv
// Loadable saturating down-counter that times each sequencer phase.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (count -> 0)
//   load_i       : load load_val_i this cycle (takes priority over hold)
//   load_val_i   : value to load
//   hold_i       : freeze the count
//   count_o      : current count
//   zero_o       : count is zero (phase expiry condition)
module train_timer import train_pkg::*; #(
  parameter int unsigned Width = TIMER_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             hold_i,
  output logic [Width-1:0] count_o,
  output logic             zero_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (!hold_i && (count_q != '0)) begin
      // Saturate at zero; never wraps.
      count_d = count_q - One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/train_sequencer.sv
// Moore FSM sequencing one station-to-station cycle: warning, run, brake, dwell.
// Optional feature macro: SEQ_WATCHDOG_EN adds a FAULT state entered when the
// RUN timer expires without a station/stop request; only rst_n leaves FAULT.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : train_sequencer_if.slave (inputs, durations, state and enables)
// Parameter:
//   T_WARN     : departure-warning duration in clk cycles
module train_sequencer import train_pkg::*; #(
  parameter logic [TIMER_W-1:0] T_WARN = T_WARN_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  train_sequencer_if.slave  bus
);

  state_e             state_q, state_d;
  logic               done_q, done_d;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_load_val;
  logic               tmr_hold;
  logic [TIMER_W-1:0] tmr_count;
  logic               tmr_zero;

  train_timer #(
    .Width (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .hold_i     (tmr_hold),
    .count_o    (tmr_count),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_hold     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Keep the counter pinned at zero while idle.
        tmr_load = 1'b1;
        if (bus.start) begin
          state_d      = StWarn;
          tmr_load_val = T_WARN;
        end
      end
      StWarn: begin
        if (bus.obstacle) begin
          tmr_hold = 1'b1;
        end else if (tmr_zero) begin
          state_d      = StRun;
          tmr_load     = 1'b1;
          tmr_load_val = bus.t_run;
        end
      end
      StRun: begin
        // Brake request wins over a coincident watchdog expiry.
        if (bus.station_det || bus.stop_req) begin
          state_d      = StBrake;
          tmr_load     = 1'b1;
          tmr_load_val = bus.t_brake;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (tmr_zero) begin
          state_d  = StFault;
          tmr_load = 1'b1;
        end
`endif
      end
      StBrake: begin
        if (tmr_zero) begin
          state_d      = StDwell;
          tmr_load     = 1'b1;
          tmr_load_val = bus.t_dwell;
        end
      end
      StDwell: begin
        // Obstacle only matters at expiry; the countdown itself keeps running.
        if (tmr_zero && !bus.obstacle) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end
`ifdef SEQ_WATCHDOG_EN
      StFault: begin
        tmr_load = 1'b1;
      end
`endif
      default: begin
        state_d  = StIdle;
        tmr_load = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign bus.present_state = state_q;
  assign bus.timer_val     = tmr_count;
  assign bus.motor_en      = (state_q == StRun);
  assign bus.door_open     = (state_q == StDwell);
  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = done_q;
`ifdef SEQ_WATCHDOG_EN
  assign bus.brake_en      = (state_q == StBrake) || (state_q == StFault);
`else
  assign bus.brake_en      = (state_q == StBrake);
`endif

endmodule

// File: tb/tb_train_sequencer.sv
// Directed and randomized bench for train_sequencer with a phase-timing
// reference model (elapsed cycles vs. loaded duration per phase).
module tb_train_sequencer;
  import train_pkg::*;

  localparam logic [TIMER_W-1:0] TW = 19'd8;
  localparam int IDLE = 0, WARN = 2, RUN = 3, BRAKE = 4, DWELL = 5, FAULT = 15;
`ifdef SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  train_sequencer_if bus ();

  train_sequencer #(
    .T_WARN (TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase, loaded duration, cycles elapsed in the phase.
  int m_state, m_dur, m_el;
  bit m_done;

  // Observed phase statistics.
  int last_len [16];
  int entries  [16];
  int cur_st, cur_len, done_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE;
    m_dur   = 0;
    m_el    = 0;
    m_done  = 1'b0;
  endtask

  function automatic int exp_timer();
    return (m_el >= m_dur) ? 0 : m_dur - m_el;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit expd;
    expd   = (m_el >= m_dur);
    m_done = 1'b0;
    case (m_state)
      IDLE: begin
        m_el = 0;
        if (bus.start) begin
          m_state = WARN; m_dur = 32'(TW);
        end else begin
          m_dur = 0;
        end
      end
      WARN: begin
        if (!bus.obstacle) begin
          if (expd) begin
            m_state = RUN; m_dur = 32'(bus.t_run); m_el = 0;
          end else m_el++;
        end
      end
      RUN: begin
        if (bus.station_det || bus.stop_req) begin
          m_state = BRAKE; m_dur = 32'(bus.t_brake); m_el = 0;
        end else if (WD && expd) begin
          m_state = FAULT; m_dur = 0; m_el = 0;
        end else if (!expd) m_el++;
      end
      BRAKE: begin
        if (expd) begin
          m_state = DWELL; m_dur = 32'(bus.t_dwell); m_el = 0;
        end else m_el++;
      end
      DWELL: begin
        if (expd && !bus.obstacle) begin
          m_state = IDLE; m_dur = 0; m_el = 0; m_done = 1'b1;
        end else if (!expd) m_el++;
      end
      default: begin
        m_dur = 0; m_el = 0;
      end
    endcase
  endtask

  task automatic check_outputs(input string when);
    check({when, ":state"}, 32'(bus.present_state), m_state);
    check({when, ":timer"}, 32'(bus.timer_val), exp_timer());
    check({when, ":motor"}, 32'(bus.motor_en), 32'(m_state == RUN));
    check({when, ":brake"}, 32'(bus.brake_en), 32'(m_state == BRAKE || m_state == FAULT));
    check({when, ":door"}, 32'(bus.door_open), 32'(m_state == DWELL));
    check({when, ":busy"}, 32'(bus.busy), 32'(m_state != IDLE));
    check({when, ":done"}, 32'(bus.done), 32'(m_done));
  endtask

  task automatic clr_stats();
    for (int i = 0; i < 16; i++) begin
      last_len[i] = 0;
      entries[i]  = 0;
    end
    done_cnt = 0;
  endtask

  task automatic track();
    int obs;
    obs = 32'(bus.present_state);
    if (obs == cur_st) cur_len++;
    else begin
      last_len[cur_st] = cur_len;
      entries[obs & 15]++;
      cur_st  = obs & 15;
      cur_len = 1;
    end
    if (bus.done) done_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs("cyc");
    track();
  endtask

  task automatic run_until(input int code, input int budget, input string tag);
    int n = 0;
    while (32'(bus.present_state) != code && n < budget) begin
      tick();
      n++;
    end
    check({tag, ":reach"}, 32'(bus.present_state), code);
  endtask

  task automatic set_inputs(input int tr, input int tb, input int td);
    bus.start = 1'b0; bus.stop_req = 1'b0; bus.station_det = 1'b0; bus.obstacle = 1'b0;
    bus.t_run = 19'(tr); bus.t_brake = 19'(tb); bus.t_dwell = 19'(td);
  endtask

  // Assert reset between edges, check outputs clear at once, release on a negedge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst_n   = 1'b1;
    cur_st  = IDLE;
    cur_len = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    set_inputs(0, 0, 0);
    clr_stats();
    #3;
    do_reset("reset");

    // Nominal cycle.
    set_inputs(100, 3, 5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_until(RUN, 20, "s1warn");
    repeat (19) tick();
    bus.station_det = 1'b1;
    tick();
    bus.station_det = 1'b0;
    run_until(IDLE, 30, "s1idle");
    repeat (3) tick();
    check("s1:warn_len", last_len[WARN], 9);
    check("s1:run_len", last_len[RUN], 20);
    check("s1:brake_len", last_len[BRAKE], 4);
    check("s1:dwell_len", last_len[DWELL], 6);
    check("s1:done_cnt", done_cnt, 1);
    check("s1:busy_after", 32'(bus.busy), 0);

    // WARN frozen by an obstacle, dual brake request, DWELL held at expiry.
    clr_stats();
    set_inputs(100, 0, 2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    bus.obstacle = 1'b1;
    repeat (5) tick();
    bus.obstacle = 1'b0;
    run_until(RUN, 30, "s2run");
    check("s2:warn_len", last_len[WARN], 14);
    bus.station_det = 1'b1;
    bus.stop_req    = 1'b1;
    bus.obstacle    = 1'b1;
    tick();
    bus.station_det = 1'b0;
    bus.stop_req    = 1'b0;
    run_until(DWELL, 5, "s2dwell");
    for (int n = 0; n < 10 && bus.timer_val != '0; n++) tick();
    repeat (10) tick();
    bus.obstacle = 1'b0;
    tick();
    check("s2:brake_len", last_len[BRAKE], 1);
    check("s2:brake_entries", entries[BRAKE], 1);
    check("s2:dwell_len", last_len[DWELL], 13);
    check("s2:done_cnt", done_cnt, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.start       = ($urandom_range(0, 3) == 0);
      bus.station_det = ($urandom_range(0, 11) == 0);
      bus.stop_req    = ($urandom_range(0, 15) == 0);
      bus.obstacle    = ($urandom_range(0, 4) == 0);
      bus.t_run       = 19'($urandom_range(0, 12));
      bus.t_brake     = 19'($urandom_range(0, 12));
      bus.t_dwell     = 19'($urandom_range(0, 12));
      tick();
    end
    set_inputs(0, 0, 0);
    #2;
    do_reset("rst_rand");

    // Asynchronous reset in the middle of BRAKE.
    clr_stats();
    set_inputs(50, 20, 3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_until(RUN, 20, "s4run");
    bus.station_det = 1'b1;
    tick();
    bus.station_det = 1'b0;
    repeat (2) tick();
    check("s4:in_brake", 32'(bus.brake_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("s4async");
    @(posedge clk);
    #1;
    check_outputs("s4hold");
    @(negedge clk);
    rst_n   = 1'b1;
    cur_st  = IDLE;
    cur_len = 0;
    repeat (10) tick();
    check("s4:no_done", done_cnt, 0);

    // RUN timer expiry with no station: watchdog or indefinite wait.
    clr_stats();
    set_inputs(10, 3, 3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_until(RUN, 20, "s5run");
`ifdef SEQ_WATCHDOG_EN
    run_until(FAULT, 15, "s5fault");
    check("s5:run_len", last_len[RUN], 11);
    bus.start = 1'b1;
    repeat (5) tick();
    bus.start = 1'b0;
    check("s5:fault_held", 32'(bus.present_state), FAULT);
    check("s5:fault_brake", 32'(bus.brake_en), 1);
`else
    repeat (20) tick();
    check("s5:still_run", 32'(bus.present_state), RUN);
    check("s5:timer_zero", 32'(bus.timer_val), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/train_sequencer.md
Name: train_sequencer

Overview:
Moore state machine that sequences one station-to-station train cycle: departure warning, run, brake, door dwell.
- Produces the 4-bit present_state code consumed by the timer selector datapath.
- Owns a 19-bit loadable down-counter that times each phase.
- Decodes the motor, brake and door enables from state.
- Sits between the operator/sensor inputs and the selector/actuator logic.

Parameters:
T_WARN, 19'd4096, departure-warning duration in clk cycles (fixed, not runtime-configurable)
TIMER_W, 19, width of timer datapath and duration inputs

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request departure; sampled only in IDLE
stop_req  input  1  operator stop request; honoured only in RUN
station_det  input  1  station sensor; honoured only in RUN
obstacle  input  1  door/platform obstruction; freezes WARN and holds DWELL
t_run  input  19  maximum run duration, sampled on entry to RUN
t_brake  input  19  brake duration, sampled on entry to BRAKE
t_dwell  input  19  door dwell duration, sampled on entry to DWELL
present_state  output  4  current state code
timer_val  output  19  current down-counter value
motor_en  output  1  high in RUN
brake_en  output  1  high in BRAKE (and FAULT when enabled)
door_open  output  1  high in DWELL
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on the DWELL->IDLE transition

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, counter=0, done=0.
  - All outputs 0 immediately, independent of clk.
  - Reset mid-cycle aborts any phase with no completion pulse.
- State codes: IDLE 4'b0000, WARN 4'b0010, RUN 4'b0011, BRAKE 4'b0100, DWELL 4'b0101, FAULT 4'b1111. No other codes are reachable.
- Outputs: registered/decoded from the state register only (Moore); no input-to-output combinational path. present_state equals the state register.
- Timer:
  - On entry to a state, counter loads that state's duration.
  - Each subsequent cycle: if counter==0 the state "expires", else counter decrements by 1.
  - A duration of N therefore gives N+1 cycles in the state; N=0 gives exactly 1 cycle.
  - The counter never wraps below 0.
- Transitions:
  - IDLE: start=1 -> WARN, load T_WARN. Otherwise remain, counter=0.
  - WARN: obstacle=1 freezes the counter (no decrement, no expiry). Expiry with obstacle=0 -> RUN, load t_run.
  - RUN:
    - station_det=1 or stop_req=1 -> BRAKE, load t_brake. Both high in the same cycle -> a single transition.
    - Counter keeps decrementing and saturates at 0; expiry has no effect unless SEQ_WATCHDOG_EN is defined.
  - BRAKE: expiry -> DWELL, load t_dwell. Inputs are ignored.
  - DWELL:
    - Expiry with obstacle=0 -> IDLE, done=1 for that one cycle, counter=0.
    - Expiry with obstacle=1 -> stay, counter held at 0, until obstacle=0.
    - obstacle during the countdown does not stop decrementing.
- Ignored inputs:
  - start is ignored outside IDLE, including the cycle of DWELL->IDLE. A start held high re-departs on the next cycle.
  - stop_req and station_det are ignored outside RUN.
- Duration inputs are sampled only on the load cycle; changes mid-phase have no effect.

Optional Feature:
SEQ_WATCHDOG_EN
- Defined:
  - Expiry of the RUN counter (no station detected within t_run+1 cycles) -> FAULT.
  - In FAULT: brake_en=1, busy=1, motor_en=0, door_open=0, counter=0.
  - FAULT is left only via rst_n.
  - If station_det/stop_req coincide with expiry, BRAKE wins.
- Undefined: the FAULT state and its logic are absent; RUN waits indefinitely for station_det/stop_req.

Decomposition:
- Package train_pkg:
  - TIMER_W.
  - State code localparams (ST_IDLE, ST_WARN, ST_RUN, ST_BRAKE, ST_DWELL, ST_FAULT), shared with the selector.
  - Default T_WARN constant.
- Sub-module train_timer:
  - 19-bit loadable down-counter.
  - Inputs: load, load_val, hold.
  - Outputs: count, zero flag.
  - Saturates at 0; reset to 0 on rst_n=0.
- The sequencer contains the FSM and output decode only.

Test Plan:
- T_WARN=8, t_run=100, t_brake=3, t_dwell=5; pulse start with station_det at cycle 20 of RUN. Required:
  - WARN lasts 9 cycles.
  - RUN exits the cycle after station_det.
  - BRAKE lasts 4 cycles, DWELL lasts 6 cycles.
  - done pulses once; busy=0 afterwards.
- obstacle high for 5 cycles mid-WARN (T_WARN=8) -> WARN lasts 14 cycles, with timer_val constant during the obstruction.
- obstacle high at DWELL expiry for 10 cycles -> door_open stays 1 with timer_val=0 for those 10 cycles; exit to IDLE and done on the first cycle obstacle=0.
- station_det and stop_req asserted together in RUN -> exactly one BRAKE entry; t_brake=0 gives a one-cycle BRAKE.
- rst_n low for 1 cycle mid-BRAKE (asynchronous, between edges) -> present_state=0000, all outputs 0 immediately; no done pulse.
- With SEQ_WATCHDOG_EN and t_run=10, no station_det -> FAULT (4'b1111) after 11 RUN cycles; brake_en=1 held; start ignored until reset. Without the macro, the same stimulus stays in RUN at timer_val=0.
